ring_counter_gen: RTL and testbench

Parametrised ring/Johnson counter, the next generation of our fixed 4-bit ring counter. It generalises width and adds a Johnson (twisted-ring) mode, selectable direction, a count enable, synchronous parallel load, a step counter with a period-wrap pulse, and illegal-state detection with optional self-correction for Johnson mode. It is used as a sequencing/phase generator: one-hot or patterned rotating enables, and 2·WIDTH-phase timing strobes.

---
 rtl/ring_counter_gen.sv | 77 +++++++
 tb/tb_ring_counter_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ring_counter_gen.sv
// Parametrised ring / Johnson counter with step count, period-wrap pulse
// and Johnson illegal-state detection with optional self-correction.
module ring_counter_gen #(
  parameter int          WIDTH = 4,
  parameter logic [31:0] INIT  = 32'd1,
  parameter bit          FIX   = 1'b1,
  localparam int         CW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             mode,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic [CW-1:0]    cnt,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] INIT_V    = INIT[WIDTH-1:0];
  localparam logic [CW-1:0]    RING_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    JOHN_LAST = CW'(2*WIDTH - 1);
  localparam logic [WIDTH-2:0] EDGE_ONE  = (WIDTH-1)'(1);

  logic             mode_q;
  logic             dir_q;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-2:0] edges;
  logic             period_end;

  // A valid Johnson code has at most one adjacent-bit transition; more than
  // one set bit in the edge vector is detected by clearing its lowest one.
  assign edges      = q[WIDTH-2:0] ^ q[WIDTH-1:1];
  assign illegal    = mode_q & (|(edges & (edges - EDGE_ONE)));
  assign period_end = (cnt == (mode_q ? JOHN_LAST : RING_LAST));

  always_comb begin
    q_next = q;
    case ({mode_q, dir_q})
      2'b00:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      2'b01:   q_next = {q[0], q[WIDTH-1:1]};
      2'b10:   q_next = {q[WIDTH-2:0], ~q[WIDTH-1]};
      default: q_next = {~q[0], q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= INIT_V;
      cnt    <= '0;
      wrap   <= 1'b0;
      mode_q <= 1'b0;
      dir_q  <= 1'b0;
    end else if (load) begin
      q      <= d;
      cnt    <= '0;
      wrap   <= 1'b0;
      mode_q <= mode;
      dir_q  <= dir;
    end else if (en) begin
      if (FIX && illegal) begin
        q    <= '0;
        cnt  <= '0;
        wrap <= 1'b0;
      end else begin
        q    <= q_next;
        cnt  <= period_end ? '0 : cnt + CW'(1);
        wrap <= period_end;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_counter_gen.sv
// Directed bench for ring_counter_gen (WIDTH=4): vector table on the FIX=1
// instance plus hand sequences for the FIX=0 instance.
module tb_ring_counter_gen;

  logic       clk = 1'b0;
  logic       rst, en, load, mode, dir;
  logic [3:0] d;

  logic [3:0] q1, q0;
  logic [2:0] cnt1, cnt0;
  logic       wrap1, wrap0, ill1, ill0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ring_counter_gen #(.WIDTH(4), .INIT(32'd1), .FIX(1'b1)) u_fix (
    .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .mode(mode), .dir(dir),
    .q(q1), .cnt(cnt1), .wrap(wrap1), .illegal(ill1)
  );

  ring_counter_gen #(.WIDTH(4), .INIT(32'd1), .FIX(1'b0)) u_nofix (
    .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .mode(mode), .dir(dir),
    .q(q0), .cnt(cnt0), .wrap(wrap0), .illegal(ill0)
  );

  typedef struct {
    logic       rst;
    logic       load;
    logic       en;
    logic [3:0] d;
    logic       mode;
    logic       dir;
    logic [3:0] q;
    logic [2:0] cnt;
    logic       wrap;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive inputs after a falling edge, clock once, return at the next falling edge.
  task automatic apply(input logic r, input logic l, input logic e, input logic [3:0] dd,
                       input logic m, input logic dr);
    rst = r; load = l; en = e; d = dd; mode = m; dir = dr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic r, input logic l, input logic e, input logic [3:0] dd,
                     input logic m, input logic dr, input logic [3:0] eq,
                     input logic [2:0] ec, input logic ew, input logic ei);
    vec_t v;
    v.rst = r; v.load = l; v.en = e; v.d = dd; v.mode = m; v.dir = dr;
    v.q = eq; v.cnt = ec; v.wrap = ew; v.ill = ei;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; d = 4'h0; mode = 1'b0; dir = 1'b0;

    //   rst load en d        mode dir  q        cnt wrap ill
    add(1, 0, 0, 4'b0000, 0, 0, 4'b0001, 0, 0, 0);
    add(1, 0, 0, 4'b0000, 0, 0, 4'b0001, 0, 0, 0);
    // ring left, arbitrary pattern
    add(0, 1, 0, 4'b1010, 0, 0, 4'b1010, 0, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b0101, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b1010, 2, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b0101, 3, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b1010, 0, 1, 0);
    // Johnson left, full 8-step period
    add(0, 1, 0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b0001, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b0011, 2, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b0111, 3, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b1111, 4, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b1110, 5, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b1100, 6, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b1000, 7, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
    // ring right, then dir toggled without load has no effect
    add(0, 1, 0, 4'b0001, 0, 1, 4'b0001, 0, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 1, 4'b1000, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 1, 4'b0100, 2, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 1, 4'b0010, 3, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 1, 4'b0001, 0, 1, 0);
    add(0, 0, 1, 4'b0000, 1, 0, 4'b1000, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 1, 1, 4'b0100, 2, 0, 0);
    // hold for 3 clocks
    add(0, 0, 0, 4'b0000, 0, 0, 4'b0100, 2, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 0, 4'b0100, 2, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 0, 4'b0100, 2, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b0010, 3, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b0001, 0, 1, 0);
    add(0, 0, 0, 4'b0000, 0, 0, 4'b0001, 0, 0, 0);
    // load + en: load wins, no step
    add(0, 1, 1, 4'b0011, 0, 0, 4'b0011, 0, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b0110, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b1100, 2, 0, 0);
    // rst + load: reset wins, back to ring left
    add(1, 1, 1, 4'b1111, 1, 1, 4'b0001, 0, 0, 0);
    add(0, 0, 1, 4'b0000, 1, 1, 4'b0010, 1, 0, 0);
    // illegal Johnson code, self-corrected on next en
    add(0, 1, 0, 4'b0101, 1, 0, 4'b0101, 0, 0, 1);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b0001, 1, 0, 0);
    // ring all-zeros still counts and wraps
    add(0, 1, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b0000, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b0000, 2, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b0000, 3, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
    // Johnson right
    add(0, 1, 0, 4'b0000, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b1000, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b1100, 2, 0, 0);
    add(0, 0, 1, 4'b0000, 0, 0, 4'b1110, 3, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].d, vecs[i].mode, vecs[i].dir);
      check("q",       i, 32'(q1),    32'(vecs[i].q));
      check("cnt",     i, 32'(cnt1),  32'(vecs[i].cnt));
      check("wrap",    i, 32'(wrap1), 32'(vecs[i].wrap));
      check("illegal", i, 32'(ill1),  32'(vecs[i].ill));
    end

    // FIX=0: illegal Johnson code keeps shifting, counting and wrapping.
    apply(0, 1, 0, 4'b0101, 1, 0);
    check("nofix_ill_load", 0, 32'(ill0), 32'd1);
    check("nofix_q_load",   0, 32'(q0),   32'h5);
    apply(0, 0, 1, 4'b0000, 0, 0);
    check("nofix_q_step1",   1, 32'(q0),   32'hB);
    check("nofix_cnt_step1", 1, 32'(cnt0), 32'd1);
    check("nofix_ill_step1", 1, 32'(ill0), 32'd1);
    check("fix_q_step1",     1, 32'(q1),   32'h0);
    check("fix_ill_step1",   1, 32'(ill1), 32'd0);
    for (int s = 2; s <= 7; s++) begin
      apply(0, 0, 1, 4'b0000, 0, 0);
      check("nofix_cnt_run",  s, 32'(cnt0),  32'(s));
      check("nofix_wrap_run", s, 32'(wrap0), 32'd0);
    end
    check("nofix_q_step7", 7, 32'(q0), 32'h2);
    apply(0, 0, 1, 4'b0000, 0, 0);
    check("nofix_q_step8",    8, 32'(q0),    32'h5);
    check("nofix_cnt_step8",  8, 32'(cnt0),  32'd0);
    check("nofix_wrap_step8", 8, 32'(wrap0), 32'd1);
    check("nofix_ill_step8",  8, 32'(ill0),  32'd1);
    apply(0, 0, 0, 4'b0000, 0, 0);
    check("nofix_wrap_clear", 9, 32'(wrap0), 32'd0);

    // Reset during load on the FIX=0 instance restores INIT, ring mode.
    apply(1, 1, 0, 4'b0110, 1, 1);
    check("nofix_rst_q",   10, 32'(q0),   32'h1);
    check("nofix_rst_ill", 10, 32'(ill0), 32'd0);
    apply(0, 0, 1, 4'b0000, 1, 1);
    check("nofix_rst_step", 11, 32'(q0), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
